// File: rtl/serial_frame_tx.sv
// Parallel-in/serial-out frame transmitter: loads a word via valid/ready, shifts it
// out one bit per bit_tick in the selected order, optionally followed by a parity bit.
module serial_frame_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned IDLE_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  bit_tick,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t                state_q, state_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt, shift_adv;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  par_q, par_nxt;
    logic                  serial_nxt, busy_nxt, ready_nxt, done_nxt;

    // Bit currently at the output end of a shift-register image.
    function automatic logic head(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    // Register contents after one advance toward the output end.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_adv = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            shift_adv = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            serial_out <= 1'(IDLE_LEVEL);
            busy       <= 1'b0;
            load_ready <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            shift_q    <= shift_nxt;
            cnt_q      <= cnt_nxt;
            par_q      <= par_nxt;
            serial_out <= serial_nxt;
            busy       <= busy_nxt;
            load_ready <= ready_nxt;
            frame_done <= done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state_q;
        shift_nxt  = shift_q;
        cnt_nxt    = cnt_q;
        par_nxt    = par_q;
        serial_nxt = serial_out;
        busy_nxt   = busy;
        ready_nxt  = load_ready;
        done_nxt   = 1'b0;

        case (state_q)
            IDLE: begin
                serial_nxt = 1'(IDLE_LEVEL);
                busy_nxt   = 1'b0;
                ready_nxt  = 1'b1;
                // A tick coinciding with the load is deliberately not acted on here.
                if (load_valid && load_ready) begin
                    state_nxt  = SHIFT;
                    shift_nxt  = data_in;
                    cnt_nxt    = CNT_W'(DATA_WIDTH - 1);
                    par_nxt    = (^data_in) ^ 1'(ODD_PARITY);
                    serial_nxt = head(data_in);
                    busy_nxt   = 1'b1;
                    ready_nxt  = 1'b0;
                end
            end

            SHIFT: begin
                if (bit_tick) begin
                    if (cnt_q != '0) begin
                        shift_nxt  = shift_adv;
                        cnt_nxt    = cnt_q - CNT_W'(1);
                        serial_nxt = head(shift_adv);
                    end else if (PARITY_EN != 0) begin
                        state_nxt  = PARITY;
                        serial_nxt = par_q;
                    end else begin
                        state_nxt  = IDLE;
                        serial_nxt = 1'(IDLE_LEVEL);
                        busy_nxt   = 1'b0;
                        ready_nxt  = 1'b1;
                        done_nxt   = 1'b1;
                    end
                end
            end

            PARITY: begin
                if (bit_tick) begin
                    state_nxt  = IDLE;
                    serial_nxt = 1'(IDLE_LEVEL);
                    busy_nxt   = 1'b0;
                    ready_nxt  = 1'b1;
                    done_nxt   = 1'b1;
                end
            end

            default: begin
                state_nxt  = IDLE;
                serial_nxt = 1'(IDLE_LEVEL);
                busy_nxt   = 1'b0;
                ready_nxt  = 1'b1;
            end
        endcase
    end

endmodule
